// File: rtl/spike_pkg.sv
// rtl/spike_pkg.sv - shared widths, FSM encoding and event field helpers for spike_scatter
package spike_pkg;

    localparam int DEF_TEN_WIDTH  = 2;
    localparam int DEF_ID_WIDTH   = 7;
    localparam int DEF_EV_WIDTH   = DEF_TEN_WIDTH + DEF_ID_WIDTH;
    localparam int DROP_CNT_WIDTH = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_e;

    // Event layout is {value, neuron_id}, value in the upper bits.
    function automatic logic [DEF_ID_WIDTH-1:0] ev_id(input logic [DEF_EV_WIDTH-1:0] ev);
        return ev[DEF_ID_WIDTH-1:0];
    endfunction

    function automatic logic [DEF_TEN_WIDTH-1:0] ev_value(input logic [DEF_EV_WIDTH-1:0] ev);
        return ev[DEF_EV_WIDTH-1 -: DEF_TEN_WIDTH];
    endfunction

    function automatic logic [DEF_EV_WIDTH-1:0] ev_pack(input logic [DEF_TEN_WIDTH-1:0] value,
                                                        input logic [DEF_ID_WIDTH-1:0]  id);
        return {value, id};
    endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// rtl/spike_event_fifo.sv - small sync event FIFO; push/pop only take effect while top_en is high
module spike_event_fifo #(
    parameter int DW = 9,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          top_en,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign level = wptr_q - rptr_q;
    assign rdata = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (top_en && push && !full) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d                = wptr_q + (AW+1)'(1);
        end
        if (top_en && pop && !empty) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: rtl/spike_scatter.sv
// rtl/spike_scatter.sv - buffers {value, id} spike events and scatters them into the per-neuron state vector
module spike_scatter
    import spike_pkg::*;
#(
    parameter int TEN_DATA_WIDTH  = DEF_TEN_WIDTH,
    parameter int NUM_NEURON      = 128,
    parameter int NEURON_ID_WIDTH = DEF_ID_WIDTH,
    parameter int FIFO_AW         = 2
) (
    input  logic                                      clk,
    input  logic                                      reset_l,
    input  logic                                      top_en,
    input  logic                                      clear,
    input  logic [3:0]                                bits_in_active_neuron,
    input  logic                                      ev_valid,
    output logic                                      ev_ready,
    input  logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] ev_data,
    output logic [TEN_DATA_WIDTH*NUM_NEURON-1:0]      spike_state,
    output logic                                      upd_valid,
    output logic [NEURON_ID_WIDTH-1:0]                upd_id,
    output logic [TEN_DATA_WIDTH-1:0]                 upd_value,
    output logic [DROP_CNT_WIDTH-1:0]                 drop_cnt,
    output logic [FIFO_AW:0]                          fifo_level,
    output logic                                      idle
);
    localparam int TEN = TEN_DATA_WIDTH;
    localparam int IDW = NEURON_ID_WIDTH;
    localparam int EVW = TEN + IDW;
    localparam int SW  = $clog2(TEN * NUM_NEURON);

    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [EVW-1:0]  fifo_rdata;
    logic [IDW:0]    limit;
    logic            in_range;
    logic [SW-1:0]   wr_base;

    state_e                      state_q, state_d;
    logic [IDW-1:0]              cur_id_q, cur_id_d;
    logic [TEN-1:0]              cur_val_q, cur_val_d;
    logic [TEN*NUM_NEURON-1:0]   spike_state_q, spike_state_d;
    logic                        upd_valid_q, upd_valid_d;
    logic [IDW-1:0]              upd_id_q, upd_id_d;
    logic [TEN-1:0]              upd_value_q, upd_value_d;
    logic [DROP_CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

    assign ev_ready  = top_en & ~fifo_full;
    assign fifo_push = ev_valid & ev_ready;
    assign fifo_pop  = (state_q == S_IDLE) & ~fifo_empty;

    spike_event_fifo #(.DW(EVW), .AW(FIFO_AW)) u_fifo (
        .clk    (clk),
        .reset_l(reset_l),
        .top_en (top_en),
        .push   (fifo_push),
        .wdata  (ev_data),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // Out-of-band widths fall back to the smallest array (4 neurons).
    always_comb begin
        limit = (IDW+1)'(4);
        if (bits_in_active_neuron >= 4'd3 && int'(bits_in_active_neuron) <= IDW) begin
            limit = (IDW+1)'(1) << bits_in_active_neuron;
        end
    end

    assign in_range = ({1'b0, cur_id_q} < limit);
    assign wr_base  = SW'(TEN * int'(cur_id_q));

    always_comb begin
        state_d       = state_q;
        cur_id_d      = cur_id_q;
        cur_val_d     = cur_val_q;
        spike_state_d = spike_state_q;
        upd_valid_d   = 1'b0;
        upd_id_d      = upd_id_q;
        upd_value_d   = upd_value_q;
        drop_cnt_d    = drop_cnt_q;
        if (top_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        cur_id_d  = fifo_rdata[IDW-1:0];
                        cur_val_d = fifo_rdata[EVW-1 -: TEN];
                        state_d   = S_WRITE;
                    end
                end
                S_WRITE: begin
                    state_d = S_IDLE;
                    // A coincident clear wins: the pending write is discarded outright.
                    if (!clear) begin
                        if (in_range) begin
                            spike_state_d[wr_base +: TEN] = cur_val_q;
                            upd_valid_d                   = 1'b1;
                            upd_id_d                      = cur_id_q;
                            upd_value_d                   = cur_val_q;
                        end else if (drop_cnt_q != '1) begin
                            drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (clear) begin
                spike_state_d = '0;
                drop_cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q       <= S_IDLE;
            cur_id_q      <= '0;
            cur_val_q     <= '0;
            spike_state_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_id_q      <= '0;
            upd_value_q   <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cur_id_q      <= cur_id_d;
            cur_val_q     <= cur_val_d;
            spike_state_q <= spike_state_d;
            upd_valid_q   <= upd_valid_d;
            upd_id_q      <= upd_id_d;
            upd_value_q   <= upd_value_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign spike_state = spike_state_q;
    assign upd_valid   = upd_valid_q;
    assign upd_id      = upd_id_q;
    assign upd_value   = upd_value_q;
    assign drop_cnt    = drop_cnt_q;
    assign idle        = fifo_empty & (state_q == S_IDLE);

endmodule

// File: tb/tb_spike_scatter.sv
// tb/tb_spike_scatter.sv - self-checking scoreboard bench for spike_scatter
module tb_spike_scatter;
    import spike_pkg::*;

    logic         clk = 1'b0;
    logic         reset_l;
    logic         top_en;
    logic         clear;
    logic [3:0]   bits_in;
    logic         ev_valid;
    logic         ev_ready;
    logic [8:0]   ev_data;
    logic [255:0] spike_state;
    logic         upd_valid;
    logic [6:0]   upd_id;
    logic [1:0]   upd_value;
    logic [7:0]   drop_cnt;
    logic [2:0]   fifo_level;
    logic         idle;

    typedef struct {
        logic [6:0] id;
        logic [1:0] val;
        bit         inr;
    } exp_t;

    exp_t         sb[$];
    logic [255:0] model_vec;
    int           model_drop;
    int           pulse_cnt;
    bit           prev_uv;
    int           chk_cnt;
    int           pass_cnt;

    spike_scatter dut (
        .clk                  (clk),
        .reset_l              (reset_l),
        .top_en               (top_en),
        .clear                (clear),
        .bits_in_active_neuron(bits_in),
        .ev_valid             (ev_valid),
        .ev_ready             (ev_ready),
        .ev_data              (ev_data),
        .spike_state          (spike_state),
        .upd_valid            (upd_valid),
        .upd_id               (upd_id),
        .upd_value            (upd_value),
        .drop_cnt             (drop_cnt),
        .fifo_level           (fifo_level),
        .idle                 (idle)
    );

    always #5 clk = ~clk;

    function automatic bit in_range(input int id);
        int b;
        int lim;
        b   = int'(bits_in);
        lim = (b >= 3 && b <= 7) ? (1 << b) : 4;
        return id < lim;
    endfunction

    function automatic void bump_drop();
        if (model_drop < 255) model_drop++;
    endfunction

    // Scoreboard consumer: every write pulse must match the oldest in-range event.
    always @(negedge clk) begin
        exp_t e;
        if (upd_valid === 1'b1) begin
            pulse_cnt++;
            while (sb.size() > 0 && !sb[0].inr) begin
                void'(sb.pop_front());
                bump_drop();
            end
            chk_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL upd_unexpected: got id=%0d val=%0d, required no write", upd_id, upd_value);
            end else begin
                e = sb.pop_front();
                if (prev_uv || upd_id !== e.id || upd_value !== e.val ||
                    spike_state[2*e.id +: 2] !== e.val) begin
                    $display("FAIL upd_write: got id=%0d val=%0d slice=%0d prev_pulse=%0d, required id=%0d val=%0d single pulse",
                             upd_id, upd_value, spike_state[2*e.id +: 2], prev_uv, e.id, e.val);
                end else begin
                    pass_cnt++;
                end
                model_vec[2*e.id +: 2] = e.val;
            end
        end
        prev_uv = (upd_valid === 1'b1);
    end

    task automatic send(input int id, input int val);
        int n = 0;
        ev_data  = ev_pack(2'(val), 7'(id));
        ev_valid = 1'b1;
        #1;
        while (ev_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk_cnt++;
        if (ev_ready !== 1'b1) begin
            $display("FAIL send_timeout: ev_ready=%b after %0d cycles, required 1", ev_ready, n);
        end else begin
            pass_cnt++;
            sb.push_back('{id: 7'(id), val: 2'(val), inr: in_range(id)});
        end
        @(negedge clk);
        ev_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (idle !== 1'b1 && n < max_cyc);
        chk_cnt++;
        if (idle !== 1'b1) $display("FAIL wait_idle: idle=%b after %0d cycles, required 1", idle, n);
        else pass_cnt++;
        @(negedge clk);
        #1;
        while (sb.size() > 0 && !sb[0].inr) begin
            void'(sb.pop_front());
            bump_drop();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_cnt++;
        if (ev_ready !== 1'b0 || idle !== 1'b1 || fifo_level !== 3'd0 || spike_state !== '0 ||
            upd_valid !== 1'b0 || upd_id !== 7'd0 || upd_value !== 2'd0 || drop_cnt !== 8'd0) begin
            $display("FAIL reset_state: rdy=%b idle=%b lvl=%0d st=%h uv=%b id=%0d v=%0d drop=%0d, required 0/1/0/0/0/0/0/0",
                     ev_ready, idle, fifo_level, spike_state, upd_valid, upd_id, upd_value, drop_cnt);
        end else pass_cnt++;
        reset_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        top_en  = 1'b1;
        bits_in = 4'd7;
        send(5, 2);
        #1;
        chk_cnt++;
        if (spike_state[11:10] !== 2'b00 || upd_valid !== 1'b0 || fifo_level !== 3'd1)
            $display("FAIL basic_e0: slice=%b uv=%b lvl=%0d, required 00/0/1", spike_state[11:10], upd_valid, fifo_level);
        else pass_cnt++;
        @(negedge clk);
        #1;
        chk_cnt++;
        if (spike_state[11:10] !== 2'b00 || fifo_level !== 3'd0 || idle !== 1'b0)
            $display("FAIL basic_e1: slice=%b lvl=%0d idle=%b, required 00/0/0", spike_state[11:10], fifo_level, idle);
        else pass_cnt++;
        @(negedge clk);
        #1;
        chk_cnt++;
        if (spike_state[11:10] !== 2'b10 || upd_valid !== 1'b1 || upd_id !== 7'd5 || upd_value !== 2'd2)
            $display("FAIL basic_e2: slice=%b uv=%b id=%0d v=%0d, required 10/1/5/2",
                     spike_state[11:10], upd_valid, upd_id, upd_value);
        else pass_cnt++;
        @(negedge clk);
        #1;
        chk_cnt++;
        if (upd_valid !== 1'b0 || idle !== 1'b1 || sb.size() != 0)
            $display("FAIL basic_e3: uv=%b idle=%b pending=%0d, required 0/1/0", upd_valid, idle, sb.size());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int exp_cyc[8] = '{0, 1, 2, 3, 4, 5, 6, 8};
        bits_in  = 4'd7;
        ev_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && sent < 8; cyc++) begin
            ev_data = ev_pack(2'((sent % 3) + 1), 7'(60 + sent));
            #1;
            if (cyc == 7) begin
                chk_cnt++;
                if (fifo_level !== 3'd4 || ev_ready !== 1'b0)
                    $display("FAIL b2b_full: lvl=%0d rdy=%b, required 4/0", fifo_level, ev_ready);
                else pass_cnt++;
            end
            if (ev_ready === 1'b1) begin
                chk_cnt++;
                if (cyc != exp_cyc[sent])
                    $display("FAIL b2b_accept: event %0d accepted in cycle %0d, required %0d", sent, cyc, exp_cyc[sent]);
                else pass_cnt++;
                sb.push_back('{id: 7'(60 + sent), val: 2'((sent % 3) + 1), inr: 1'b1});
                sent++;
            end
            @(negedge clk);
        end
        ev_valid = 1'b0;
        wait_idle(40);
        chk_cnt++;
        if (sent != 8 || sb.size() != 0 || idle !== 1'b1 || spike_state !== model_vec)
            $display("FAIL b2b_drain: sent=%0d pending=%0d idle=%b st=%h, required 8/0/1 st=%h",
                     sent, sb.size(), idle, spike_state, model_vec);
        else pass_cnt++;
    endtask

    task automatic test_range();
        bits_in = 4'd4;
        send(20, 1);
        wait_idle(20);
        chk_cnt++;
        if (drop_cnt !== 8'd1 || drop_cnt !== 8'(model_drop) || spike_state !== model_vec)
            $display("FAIL range_drop20: drop=%0d st=%h, required 1 st=%h", drop_cnt, spike_state, model_vec);
        else pass_cnt++;
        send(15, 2);
        wait_idle(20);
        chk_cnt++;
        if (spike_state[31:30] !== 2'd2 || drop_cnt !== 8'd1 || sb.size() != 0)
            $display("FAIL range_write15: slice=%0d drop=%0d pending=%0d, required 2/1/0",
                     spike_state[31:30], drop_cnt, sb.size());
        else pass_cnt++;
        bits_in = 4'd9;
        send(3, 3);
        send(4, 1);
        wait_idle(20);
        chk_cnt++;
        if (spike_state[7:6] !== 2'd3 || drop_cnt !== 8'd2 || spike_state !== model_vec || sb.size() != 0)
            $display("FAIL range_bits9: slice3=%0d drop=%0d pending=%0d st=%h, required 3/2/0 st=%h",
                     spike_state[7:6], drop_cnt, sb.size(), spike_state, model_vec);
        else pass_cnt++;
    endtask

    task automatic test_repeat_id();
        int p0;
        bits_in = 4'd7;
        p0      = pulse_cnt;
        send(33, 1);
        send(33, 3);
        wait_idle(20);
        chk_cnt++;
        if (spike_state[67:66] !== 2'd3 || pulse_cnt - p0 != 2 || sb.size() != 0)
            $display("FAIL repeat_id: slice=%0d pulses=%0d, required 3/2", spike_state[67:66], pulse_cnt - p0);
        else pass_cnt++;
    endtask

    task automatic test_freeze();
        bits_in = 4'd7;
        for (int i = 0; i < 4; i++) send(40 + i, (i % 3) + 1);
        top_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk_cnt++;
            if (fifo_level !== 3'd2 || upd_valid !== 1'b0 || ev_ready !== 1'b0 || spike_state !== model_vec)
                $display("FAIL freeze_c%0d: lvl=%0d uv=%b rdy=%b, required 2/0/0 and unchanged state",
                         c, fifo_level, upd_valid, ev_ready);
            else pass_cnt++;
        end
        top_en = 1'b1;
        wait_idle(30);
        chk_cnt++;
        if (sb.size() != 0 || spike_state !== model_vec || spike_state[87:86] !== 2'd1)
            $display("FAIL freeze_resume: pending=%0d st=%h, required 0 st=%h", sb.size(), spike_state, model_vec);
        else pass_cnt++;
    endtask

    task automatic test_saturate_clear();
        bits_in = 4'd3;
        for (int i = 0; i < 300; i++) send(8 + (i % 120), i % 4);
        wait_idle(100);
        chk_cnt++;
        if (drop_cnt !== 8'd255 || model_drop != 255 || sb.size() != 0 || spike_state !== model_vec)
            $display("FAIL drop_saturate: drop=%0d pending=%0d, required 255/0", drop_cnt, sb.size());
        else pass_cnt++;
        bits_in = 4'd7;
        send(9, 3);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk_cnt++;
        if (spike_state[19:18] !== 2'd0 || upd_valid !== 1'b0 || drop_cnt !== 8'd0 || spike_state !== '0)
            $display("FAIL clear_write: slice=%0d uv=%b drop=%0d st=%h, required 0/0/0 all-zero",
                     spike_state[19:18], upd_valid, drop_cnt, spike_state);
        else pass_cnt++;
        sb.delete();
        model_vec  = '0;
        model_drop = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_cnt++;
        if (idle !== 1'b1 || spike_state !== '0)
            $display("FAIL clear_after: idle=%b st=%h, required 1 all-zero", idle, spike_state);
        else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        bits_in = 4'd7;
        send(10, 1);
        send(11, 2);
        send(12, 3);
        #2;
        reset_l = 1'b0;
        #1;
        chk_cnt++;
        if (spike_state !== '0 || upd_valid !== 1'b0 || upd_id !== 7'd0 || upd_value !== 2'd0 ||
            drop_cnt !== 8'd0 || fifo_level !== 3'd0 || idle !== 1'b1 || ev_ready !== 1'b1)
            $display("FAIL reset_mid: st=%h uv=%b id=%0d v=%0d drop=%0d lvl=%0d idle=%b rdy=%b, required zeros idle=1 rdy=1",
                     spike_state, upd_valid, upd_id, upd_value, drop_cnt, fifo_level, idle, ev_ready);
        else pass_cnt++;
        sb.delete();
        model_vec  = '0;
        model_drop = 0;
        @(negedge clk);
        reset_l = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk_cnt++;
        if (spike_state !== '0 || idle !== 1'b1 || drop_cnt !== 8'd0)
            $display("FAIL reset_lost: st=%h idle=%b drop=%0d, required all-zero/1/0", spike_state, idle, drop_cnt);
        else pass_cnt++;
    endtask

    initial begin
        reset_l    = 1'b0;
        top_en     = 1'b0;
        clear      = 1'b0;
        bits_in    = 4'd7;
        ev_valid   = 1'b0;
        ev_data    = '0;
        model_vec  = '0;
        model_drop = 0;
        pulse_cnt  = 0;
        prev_uv    = 1'b0;
        chk_cnt    = 0;
        pass_cnt   = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_range();
        test_repeat_id();
        test_freeze();
        test_saturate_clear();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
